// File: rtl/aes_pkg.sv
// Shared AES definitions for the column-mixing datapath:
// field polynomial, coefficient rows, FSM states, GF helpers.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  // Circulant first rows, byte 0 in the MSB.
  localparam logic [31:0] FWD_ROW = 32'h02030101;
  localparam logic [31:0] INV_ROW = 32'h0E0B0D09;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a coefficient below 16 using
  // a fixed xtime chain; c selects which powers are summed.
  function automatic logic [7:0] gf_mul4(
    input logic [7:0] a,
    input logic [3:0] c
  );
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & a)
         ^ ({8{c[1]}} & x2)
         ^ ({8{c[2]}} & x4)
         ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/mix_column_gf.sv
// Combinational (Inv)MixColumns on one 32-bit column.
// col_in/col_out: byte 0 in [31:24]; inv selects the inverse.
module mix_column_gf
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [31:0] row;

  assign row = inv ? INV_ROW : FWD_ROW;

  // Output byte r takes coefficient row[(j-r) mod 4]
  // against input byte j; only the low nibble is nonzero.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        col_out[31-8*r -: 8] = col_out[31-8*r -: 8]
          ^ gf_mul4(col_in[31-8*j -: 8],
                    row[27-8*((j-r)&3) -: 4]);
      end
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns/InvMixColumns over the 128-bit state,
// COLS_PER_CYCLE columns per clock, valid/ready on both sides.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int C = COLS_PER_CYCLE;

  if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  if (TAG_W < 1) begin : g_bad_tag
    $error("TAG_W must be at least 1");
  end

  // With C=4 the step wraps to 0 and idx stays 0.
  localparam logic [1:0] STEP     = 2'(C);
  localparam logic [1:0] LAST_IDX = 2'(4 - C);

  mc_state_e        state_q;
  mc_state_e        state_d;
  logic [127:0]     work_q;
  logic [127:0]     work_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic             inv_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;

  logic [1:0]  col_idx [C];
  logic [31:0] col_in  [C];
  logic [31:0] col_out [C];

  for (genvar g = 0; g < C; g++) begin : g_col
    assign col_idx[g] = idx_q + 2'(g);
    assign col_in[g]  = work_q[127-32*col_idx[g] -: 32];

    mix_column_gf u_mix (
      .col_in  (col_in[g]),
      .inv     (inv_q),
      .col_out (col_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      BUSY: begin
        for (int g = 0; g < C; g++) begin
          work_d[127-32*col_idx[g] -: 32] = col_out[g];
        end
        idx_d = idx_q + STEP;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = in_valid && in_ready && !flush;

    if (accept) begin
      work_d  = in_state;
      idx_d   = '0;
      state_d = BUSY;
    end

    // Abort freezes the work register at its current value.
    if (flush) begin
      work_d  = work_q;
      idx_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      idx_q   <= '0;
      inv_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      if (accept) begin
        inv_q <= in_inv;
        tag_q <= in_tag;
      end
    end
  end

  assign out_state = work_q;
  assign out_tag   = tag_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter at widths 1, 2 and 4,
// against a generic GF(2^8) matrix-multiply reference model.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         iv   [3];
  logic         ir   [3];
  logic         inv  [3];
  logic         fl   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         bz   [3];
  logic [127:0] ist  [3];
  logic [127:0] ost  [3];
  logic [3:0]   itag [3];
  logic [3:0]   otag [3];

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] F_IN  =
    128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] F_OUT =
    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] I_IN  =
    128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] I_OUT =
    128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_columns_iter #(
      .COLS_PER_CYCLE (1 << k),
      .TAG_W          (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[k]),
      .in_ready  (ir[k]),
      .in_state  (ist[k]),
      .in_inv    (inv[k]),
      .in_tag    (itag[k]),
      .flush     (fl[k]),
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .out_state (ost[k]),
      .out_tag   (otag[k]),
      .busy      (bz[k])
    );
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(
    input logic [7:0] a_in,
    input logic [7:0] b_in
  );
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    logic       hi;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(
    input logic [127:0] s,
    input logic         m
  );
    logic [7:0]   row [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (m) row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else   row = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(s[127-32*c-8*j -: 8],
                           row[(j - i + 4) % 4]);
        end
        r[127-32*c-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ist[k]  = '0;
      inv[k]  = 1'b0;
      itag[k] = '0;
      fl[k]   = 1'b0;
      ordy[k] = 1'b1;
    end
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!ov[k] && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_txn(
    input  int           k,
    input  logic [127:0] s,
    input  logic         m,
    input  logic [3:0]   t,
    output logic [127:0] res
  );
    int n;
    logic [127:0] exp_s;
    n = 0;
    while (!ir[k] && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (ir[k] !== 1'b1) begin
      errors++;
      $display("FAIL ready c=%0d: in_ready=%b want 1",
               1 << k, ir[k]);
    end
    iv[k]   = 1'b1;
    ist[k]  = s;
    inv[k]  = m;
    itag[k] = t;
    step();
    iv[k]   = 1'b0;
    inv[k]  = ~m;
    ist[k]  = rnd128();
    itag[k] = ~t;
    wait_valid(k, n);
    checks++;
    if (n != (4 >> k)) begin
      errors++;
      $display("FAIL latency c=%0d: got %0d want %0d",
               1 << k, n, 4 >> k);
    end
    exp_s = mix_ref(s, m);
    checks++;
    if (ost[k] !== exp_s) begin
      errors++;
      $display("FAIL state c=%0d inv=%b: got %h want %h",
               1 << k, m, ost[k], exp_s);
    end
    checks++;
    if (otag[k] !== t) begin
      errors++;
      $display("FAIL tag c=%0d: got %h want %h",
               1 << k, otag[k], t);
    end
    res = ost[k];
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 ||
          bz[k] !== 1'b0 || ost[k] !== '0 ||
          otag[k] !== 4'h0) begin
        errors++;
        $display("FAIL reset c=%0d: rdy=%b v=%b b=%b s=%h t=%h want 1 0 0 0 0",
                 1 << k, ir[k], ov[k], bz[k], ost[k], otag[k]);
      end
    end
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || bz[k] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset c=%0d: rdy=%b v=%b b=%b want 1 0 0",
                 1 << k, ir[k], ov[k], bz[k]);
      end
    end
  endtask

  task automatic test_forward();
    logic [127:0] r;
    for (int k = 0; k < 3; k++) begin
      run_txn(k, F_IN, 1'b0, 4'(k + 1), r);
      checks++;
      if (r !== F_OUT) begin
        errors++;
        $display("FAIL fwd_vec c=%0d: got %h want %h", 1 << k, r, F_OUT);
      end
    end
  endtask

  task automatic test_inverse();
    logic [127:0] r;
    for (int k = 0; k < 3; k++) begin
      run_txn(k, I_IN, 1'b1, 4'hA, r);
      checks++;
      if (r !== I_OUT) begin
        errors++;
        $display("FAIL inv_vec c=%0d: got %h want %h", 1 << k, r, I_OUT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] ea;
    logic [127:0] eb;
    int n;
    for (int k = 0; k < 3; k++) begin
      a  = rnd128();
      b  = rnd128();
      ea = mix_ref(a, 1'b0);
      eb = mix_ref(b, 1'b1);
      ordy[k] = 1'b0;
      iv[k]   = 1'b1;
      ist[k]  = a;
      inv[k]  = 1'b0;
      itag[k] = 4'h3;
      step();
      iv[k] = 1'b0;
      wait_valid(k, n);
      checks++;
      if (n != (4 >> k) || ost[k] !== ea) begin
        errors++;
        $display("FAIL bp_first c=%0d: lat=%0d s=%h want %0d %h",
                 1 << k, n, ost[k], 4 >> k, ea);
      end
      for (int i = 0; i < 5; i++) begin
        step();
        checks++;
        if (ost[k] !== ea || otag[k] !== 4'h3 ||
            ir[k] !== 1'b0 || ov[k] !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold c=%0d: s=%h t=%h rdy=%b v=%b want %h 3 0 1",
                   1 << k, ost[k], otag[k], ir[k], ov[k], ea);
        end
      end
      ordy[k] = 1'b1;
      iv[k]   = 1'b1;
      ist[k]  = b;
      inv[k]  = 1'b1;
      itag[k] = 4'h5;
      #1;
      checks++;
      if (ir[k] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready c=%0d: in_ready=%b want 1", 1 << k, ir[k]);
      end
      step();
      iv[k] = 1'b0;
      checks++;
      if (bz[k] !== 1'b1 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_accept c=%0d: busy=%b v=%b want 1 0",
                 1 << k, bz[k], ov[k]);
      end
      wait_valid(k, n);
      checks++;
      if (n != (4 >> k) || ost[k] !== eb || otag[k] !== 4'h5) begin
        errors++;
        $display("FAIL b2b_second c=%0d: lat=%0d s=%h t=%h want %0d %h 5",
                 1 << k, n, ost[k], otag[k], 4 >> k, eb);
      end
      step();
    end
  endtask

  task automatic test_flush();
    logic [127:0] a;
    logic [127:0] part;
    logic [127:0] full;
    logic seen;
    a    = rnd128();
    full = mix_ref(a, 1'b0);
    part = a;
    part[127:96] = full[127:96];
    iv[0]   = 1'b1;
    ist[0]  = a;
    inv[0]  = 1'b0;
    itag[0] = 4'h7;
    step();
    iv[0] = 1'b0;
    step();
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: v=%b rdy=%b busy=%b want 0 1 0",
               ov[0], ir[0], bz[0]);
    end
    checks++;
    if (ost[0] !== part) begin
      errors++;
      $display("FAIL flush_hold: got %h want %h", ost[0], part);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid seen=%b want 0", seen);
    end
    fl[0]  = 1'b1;
    iv[0]  = 1'b1;
    ist[0] = rnd128();
    step();
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    checks++;
    if (bz[0] !== 1'b0 || ir[0] !== 1'b1 || ost[0] !== part) begin
      errors++;
      $display("FAIL flush_accept: busy=%b rdy=%b s=%h want 0 1 %h",
               bz[0], ir[0], ost[0], part);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ov[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept_out: out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] r;
    logic seen;
    for (int k = 0; k < 2; k++) begin
      iv[k]   = 1'b1;
      ist[k]  = rnd128();
      inv[k]  = 1'b0;
      itag[k] = 4'h9;
      step();
      iv[k] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ov[k] !== 1'b0 || bz[k] !== 1'b0 ||
          otag[k] !== 4'h0 || ir[k] !== 1'b1) begin
        errors++;
        $display("FAIL async_reset c=%0d: v=%b b=%b t=%h rdy=%b want 0 0 0 1",
                 1 << k, ov[k], bz[k], otag[k], ir[k]);
      end
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (ov[k]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_result c=%0d: seen=%b want 0", 1 << k, seen);
      end
      run_txn(k, F_IN, 1'b0, 4'hC, r);
    end
  endtask

  task automatic test_random();
    logic [127:0] s;
    logic [127:0] f;
    logic [127:0] b;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        s = rnd128();
        run_txn(k, s, 1'b0, 4'($urandom_range(15)), f);
        run_txn(k, f, 1'b1, 4'($urandom_range(15)), b);
        checks++;
        if (b !== s) begin
          errors++;
          $display("FAIL round_trip c=%0d: got %h want %h", 1 << k, b, s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
